// File: rtl/external_input.sv
// Operator input unit: synchronises and debounces the ENTER button, queues the DIP-switch
// word on each press, and hands queued words to the CPU on input requests.
module external_input #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      sw,
    input  logic             enterButton,
    input  logic             inputEnable,
    input  logic             changeEnable,
    input  logic             clearOverflow,
    output logic [15:0]      dataOut,
    output logic             dataValid,
    output logic             waiting,
    output logic [CNT_W-1:0] wordCount,
    output logic             fullLed,
    output logic             overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [15:0]      sw_meta_q, sw_meta_d;
    logic [15:0]      sw_sync_q, sw_sync_d;
    logic             btn_meta_q, btn_meta_d;
    logic             btn_sync_q, btn_sync_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [0:0]       state_q, state_d;
    logic             waiting_q, waiting_d;
    logic [15:0]      data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;

    logic             request;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;

    always_comb begin
        sw_meta_d  = sw;
        sw_sync_d  = sw_meta_q;
        btn_meta_d = enterButton;
        btn_sync_d = btn_meta_q;

        // The counter only advances while the synced button disagrees with the accepted level;
        // any return to agreement restarts the stability window.
        db_cnt_d = '0;
        level_d  = level_q;
        if (btn_sync_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_comb begin
        request = inputEnable & changeEnable;
        empty   = (count_q == '0);
        full    = (count_q == DEPTH_C);

        pop       = 1'b0;
        state_d   = state_q;
        waiting_d = waiting_q;
        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d   = ST_WAIT;
                        waiting_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!empty) begin
                    pop       = 1'b1;
                    waiting_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                waiting_d = 1'b0;
            end
        endcase

        // A pop in the same cycle frees the slot, so a press on a full queue still lands.
        push = press_q & (~full | pop);

        overflow_d = overflow_q;
        if (clearOverflow) begin
            overflow_d = 1'b0;
        end
        if (press_q && full && !pop) begin
            overflow_d = 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        data_out_d   = pop ? mem_q[rd_ptr_q] : data_out_q;
        data_valid_d = pop;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            btn_meta_q   <= 1'b0;
            btn_sync_q   <= 1'b0;
            db_cnt_q     <= '0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            state_q      <= ST_IDLE;
            waiting_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
            btn_meta_q   <= btn_meta_d;
            btn_sync_q   <= btn_sync_d;
            db_cnt_q     <= db_cnt_d;
            level_q      <= level_d;
            press_q      <= press_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            waiting_q    <= waiting_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    // Queue storage needs no reset: a slot is only ever read after it has been written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sw_sync_q;
        end
    end

    assign dataOut   = data_out_q;
    assign dataValid = data_valid_q;
    assign waiting   = waiting_q;
    assign wordCount = count_q;
    assign fullLed   = (count_q == DEPTH_C);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_external_input.sv
// Directed bench for external_input with a short debounce window and a 4-deep queue;
// expected values are hand-derived from the press-to-push latency of 2 + 4 + 1 cycles.
module tb_external_input;

    logic        clock;
    logic        reset;
    logic [15:0] sw;
    logic        enterButton;
    logic        inputEnable;
    logic        changeEnable;
    logic        clearOverflow;
    logic [15:0] dataOut;
    logic        dataValid;
    logic        waiting;
    logic [2:0]  wordCount;
    logic        fullLed;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    external_input #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH(4),
        .CNT_W(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sw(sw),
        .enterButton(enterButton),
        .inputEnable(inputEnable),
        .changeEnable(changeEnable),
        .clearOverflow(clearOverflow),
        .dataOut(dataOut),
        .dataValid(dataValid),
        .waiting(waiting),
        .wordCount(wordCount),
        .fullLed(fullLed),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Clean press held long enough to be accepted, then released and allowed to settle.
    task automatic pressWord(input logic [15:0] value);
        sw = value;
        enterButton = 1'b1;
        tick(10);
        enterButton = 1'b0;
        tick(12);
    endtask

    task automatic requestWord(input string tag, input logic [15:0] exp);
        inputEnable  = 1'b1;
        changeEnable = 1'b1;
        tick(1);
        inputEnable  = 1'b0;
        changeEnable = 1'b0;
        checkOutput({tag, "_valid"}, {31'd0, dataValid}, 32'd1);
        checkOutput({tag, "_data"}, {16'd0, dataOut}, {16'd0, exp});
        tick(1);
        checkOutput({tag, "_pulse_end"}, {31'd0, dataValid}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        sw = 16'h0000;
        enterButton = 1'b0;
        inputEnable = 1'b0;
        changeEnable = 1'b0;
        clearOverflow = 1'b0;
        tick(3);
        checkOutput("rst_dataOut", {16'd0, dataOut}, 32'd0);
        checkOutput("rst_flags", {26'd0, dataValid, waiting, fullLed, overflow, 2'b00},  32'd0);
        checkOutput("rst_wordCount", {29'd0, wordCount}, 32'd0);
        reset = 1'b1;
        tick(2);

        $display("[TB] test 1: clean press latency");
        sw = 16'h1234;
        enterButton = 1'b1;
        tick(6);
        checkOutput("t1_before_push", {29'd0, wordCount}, 32'd0);
        tick(1);
        checkOutput("t1_push_edge", {29'd0, wordCount}, 32'd1);
        tick(3);
        enterButton = 1'b0;
        tick(12);
        checkOutput("t1_release", {29'd0, wordCount}, 32'd1);

        $display("[TB] test 2: bouncing button");
        sw = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            enterButton = 1'b1;
            tick(2);
            enterButton = 1'b0;
            tick(2);
        end
        checkOutput("t2_bounce_rejected", {29'd0, wordCount}, 32'd1);
        enterButton = 1'b1;
        tick(10);
        enterButton = 1'b0;
        tick(12);
        checkOutput("t2_one_push", {29'd0, wordCount}, 32'd2);
        requestWord("t2_pop1", 16'h1234);
        requestWord("t2_pop2", 16'h5555);
        checkOutput("t2_drained", {29'd0, wordCount}, 32'd0);

        $display("[TB] test 3: ordered delivery");
        pressWord(16'hA001);
        pressWord(16'hA002);
        checkOutput("t3_queued", {29'd0, wordCount}, 32'd2);
        requestWord("t3_first", 16'hA001);
        checkOutput("t3_hold", {16'd0, dataOut}, 32'h0000A001);
        requestWord("t3_second", 16'hA002);
        checkOutput("t3_empty", {29'd0, wordCount}, 32'd0);

        $display("[TB] test 4: wait state");
        inputEnable  = 1'b1;
        changeEnable = 1'b1;
        tick(1);
        inputEnable  = 1'b0;
        changeEnable = 1'b0;
        checkOutput("t4_waiting", {31'd0, waiting}, 32'd1);
        checkOutput("t4_no_valid", {31'd0, dataValid}, 32'd0);
        sw = 16'hBEEF;
        enterButton = 1'b1;
        tick(7);
        checkOutput("t4_pushed", {29'd0, wordCount}, 32'd1);
        checkOutput("t4_still_waiting", {31'd0, waiting}, 32'd1);
        tick(1);
        checkOutput("t4_valid", {31'd0, dataValid}, 32'd1);
        checkOutput("t4_data", {16'd0, dataOut}, 32'h0000BEEF);
        checkOutput("t4_released", {31'd0, waiting}, 32'd0);
        checkOutput("t4_popped", {29'd0, wordCount}, 32'd0);
        tick(1);
        checkOutput("t4_pulse_end", {31'd0, dataValid}, 32'd0);
        enterButton = 1'b0;
        tick(12);

        $display("[TB] test 5: full queue and overflow");
        pressWord(16'hC001);
        pressWord(16'hC002);
        pressWord(16'hC003);
        pressWord(16'hC004);
        checkOutput("t5_count_full", {29'd0, wordCount}, 32'd4);
        checkOutput("t5_fullLed", {31'd0, fullLed}, 32'd1);
        checkOutput("t5_no_overflow_yet", {31'd0, overflow}, 32'd0);
        pressWord(16'hC005);
        checkOutput("t5_overflow", {31'd0, overflow}, 32'd1);
        checkOutput("t5_count_held", {29'd0, wordCount}, 32'd4);
        clearOverflow = 1'b1;
        tick(1);
        clearOverflow = 1'b0;
        checkOutput("t5_cleared", {31'd0, overflow}, 32'd0);
        requestWord("t5_pop1", 16'hC001);
        requestWord("t5_pop2", 16'hC002);
        requestWord("t5_pop3", 16'hC003);
        requestWord("t5_pop4", 16'hC004);
        checkOutput("t5_fifth_absent", {29'd0, wordCount}, 32'd0);
        checkOutput("t5_fullLed_off", {31'd0, fullLed}, 32'd0);

        $display("[TB] test 6: reset while waiting");
        pressWord(16'hD001);
        pressWord(16'hD002);
        requestWord("t6_pop1", 16'hD001);
        requestWord("t6_pop2", 16'hD002);
        inputEnable  = 1'b1;
        changeEnable = 1'b1;
        tick(1);
        inputEnable  = 1'b0;
        changeEnable = 1'b0;
        checkOutput("t6_waiting", {31'd0, waiting}, 32'd1);
        enterButton = 1'b1;
        tick(3);
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_async_dataOut", {16'd0, dataOut}, 32'd0);
        checkOutput("t6_async_waiting", {31'd0, waiting}, 32'd0);
        checkOutput("t6_async_flags", {29'd0, dataValid, fullLed, overflow}, 32'd0);
        checkOutput("t6_async_wordCount", {29'd0, wordCount}, 32'd0);
        enterButton = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(10);
        checkOutput("t6_press_lost", {29'd0, wordCount}, 32'd0);
        inputEnable  = 1'b1;
        changeEnable = 1'b1;
        tick(1);
        inputEnable  = 1'b0;
        changeEnable = 1'b0;
        checkOutput("t6_rewait", {31'd0, waiting}, 32'd1);
        checkOutput("t6_rewait_no_valid", {31'd0, dataValid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
